// File: rtl/octave_clk_en_gen_if.sv
// ---------------------------------------------------------------------------
// octave_clk_en_gen_if
// Control/status bundle for the octave clock-enable generator.
//   run        : counter advance enable
//   sync_clr   : synchronous counter restart, applies pending octaves at once
//   octave_in  : requested octave per channel, channel ch at [ch*OCT_W +: OCT_W]
//   oct_load   : per-channel strobe capturing octave_in as the pending octave
//   oct_active : octave in effect per channel (clamped)
//   pending    : per-channel flag, a loaded octave waits for its boundary
//   sq_out     : per-channel divided 50%-duty square wave
//   tick_out   : per-channel one-cycle enable, once per divided period
// The master modport drives control, the slave modport is the generator.
// ---------------------------------------------------------------------------
interface octave_clk_en_gen_if #(
    parameter int NUM_CH = 4,
    parameter int OCT_W  = 3
);
    logic                      run;
    logic                      sync_clr;
    logic [NUM_CH*OCT_W-1:0]   octave_in;
    logic [NUM_CH-1:0]         oct_load;
    logic [NUM_CH*OCT_W-1:0]   oct_active;
    logic [NUM_CH-1:0]         pending;
    logic [NUM_CH-1:0]         sq_out;
    logic [NUM_CH-1:0]         tick_out;

    modport master (
        output run, sync_clr, octave_in, oct_load,
        input  oct_active, pending, sq_out, tick_out
    );

    modport slave (
        input  run, sync_clr, octave_in, oct_load,
        output oct_active, pending, sq_out, tick_out
    );
endinterface

// File: rtl/octave_clk_en_gen.sv
// ---------------------------------------------------------------------------
// octave_clk_en_gen
// One free-running counter shared by NUM_CH channels. Each channel divides
// clk by 2^(o+1) for its active octave o, giving a 50%-duty square wave and
// a one-cycle tick per period. New octaves are held pending and swapped in
// only on an edge that ends both the old and the new period, so no channel
// ever emits a runt phase.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : control/status bundle (slave side), see octave_clk_en_gen_if
// All outputs are registered.
// ---------------------------------------------------------------------------
module octave_clk_en_gen #(
    parameter int NUM_CH    = 4,
    parameter int NUM_OCT   = 8,
    parameter int OCT_W     = 3,
    parameter int RESET_OCT = 0
) (
    input  logic                clk,
    input  logic                reset,
    octave_clk_en_gen_if.slave  bus
);

    localparam logic [NUM_OCT-1:0] ONES_C = {NUM_OCT{1'b1}};
    localparam logic [OCT_W-1:0]   RESET_CODE_C = (RESET_OCT >= NUM_OCT) ?
                                   OCT_W'(NUM_OCT - 1) : OCT_W'(RESET_OCT);

    // Out-of-range octave codes saturate at the slowest octave.
    function automatic logic [OCT_W-1:0] clamp_oct(input logic [OCT_W-1:0] code);
        logic [OCT_W-1:0] res;
        if (int'(code) >= NUM_OCT) begin
            res = OCT_W'(NUM_OCT - 1);
        end else begin
            res = code;
        end
        return res;
    endfunction

    // True when cnt[o:0] is all ones, i.e. this edge ends a period of octave o.
    function automatic logic low_ones(input logic [NUM_OCT-1:0] cnt,
                                      input logic [OCT_W-1:0]   o);
        logic [NUM_OCT-1:0] mask;
        mask = ONES_C >> (NUM_OCT - 1 - int'(o));
        return ((cnt & mask) == mask);
    endfunction

    function automatic logic [OCT_W-1:0] max_oct(input logic [OCT_W-1:0] a,
                                                 input logic [OCT_W-1:0] b);
        logic [OCT_W-1:0] res;
        if (a > b) begin
            res = a;
        end else begin
            res = b;
        end
        return res;
    endfunction

    function automatic logic bit_at(input logic [NUM_OCT-1:0] v,
                                    input logic [OCT_W-1:0]   o);
        logic [NUM_OCT-1:0] sh;
        sh = v >> o;
        return sh[0];
    endfunction

    logic [NUM_OCT-1:0] cnt_r;
    logic [NUM_OCT-1:0] cnt_inc_s;
    logic [OCT_W-1:0]   act_r      [NUM_CH];
    logic [OCT_W-1:0]   pend_oct_r [NUM_CH];
    logic [OCT_W-1:0]   act_nxt_s  [NUM_CH];
    logic [OCT_W-1:0]   load_oct_s [NUM_CH];
    logic [NUM_CH-1:0]  pending_r;
    logic [NUM_CH-1:0]  sq_r;
    logic [NUM_CH-1:0]  tick_r;
    logic [NUM_CH-1:0]  swap_s;
    logic [NUM_CH-1:0]  tick_nxt_s;
    logic [NUM_CH-1:0]  sq_nxt_s;

    assign cnt_inc_s = cnt_r + NUM_OCT'(1);

    // Per-channel next-state: swap decision, tick and square-wave values.
    always_comb begin
        swap_s     = {NUM_CH{1'b0}};
        tick_nxt_s = {NUM_CH{1'b0}};
        sq_nxt_s   = {NUM_CH{1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            act_nxt_s[ch]  = act_r[ch];
            load_oct_s[ch] = clamp_oct(bus.octave_in[ch*OCT_W +: OCT_W]);
            // Swap only where both the old and the new period end together.
            swap_s[ch] = bus.run & pending_r[ch] &
                         low_ones(cnt_r, max_oct(act_r[ch], pend_oct_r[ch]));
            if (swap_s[ch]) begin
                act_nxt_s[ch] = pend_oct_r[ch];
            end else begin
                act_nxt_s[ch] = act_r[ch];
            end
            tick_nxt_s[ch] = bus.run & low_ones(cnt_r, act_r[ch]);
            // The square wave follows the post-increment count at the new octave.
            sq_nxt_s[ch] = bit_at(cnt_inc_s, act_nxt_s[ch]);
        end
    end

    // Counter, octave registers, pending flags and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= {NUM_OCT{1'b0}};
            pending_r <= {NUM_CH{1'b0}};
            sq_r      <= {NUM_CH{1'b0}};
            tick_r    <= {NUM_CH{1'b0}};
            for (int ch = 0; ch < NUM_CH; ch++) begin
                act_r[ch]      <= RESET_CODE_C;
                pend_oct_r[ch] <= RESET_CODE_C;
            end
        end else if (bus.sync_clr) begin
            cnt_r  <= {NUM_OCT{1'b0}};
            sq_r   <= {NUM_CH{1'b0}};
            tick_r <= {NUM_CH{1'b0}};
            for (int ch = 0; ch < NUM_CH; ch++) begin
                // The restart is a common boundary, so pending octaves apply now.
                if (pending_r[ch]) begin
                    act_r[ch] <= pend_oct_r[ch];
                end else begin
                    act_r[ch] <= act_r[ch];
                end
                if (bus.oct_load[ch]) begin
                    pend_oct_r[ch] <= load_oct_s[ch];
                    pending_r[ch]  <= 1'b1;
                end else begin
                    pend_oct_r[ch] <= pend_oct_r[ch];
                    pending_r[ch]  <= 1'b0;
                end
            end
        end else begin
            if (bus.run) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
            tick_r <= tick_nxt_s;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                act_r[ch] <= act_nxt_s[ch];
                if (bus.run) begin
                    sq_r[ch] <= sq_nxt_s[ch];
                end else begin
                    sq_r[ch] <= sq_r[ch];
                end
                // A load on the swap edge becomes the next pending value.
                if (bus.oct_load[ch]) begin
                    pend_oct_r[ch] <= load_oct_s[ch];
                    pending_r[ch]  <= 1'b1;
                end else if (swap_s[ch]) begin
                    pend_oct_r[ch] <= pend_oct_r[ch];
                    pending_r[ch]  <= 1'b0;
                end else begin
                    pend_oct_r[ch] <= pend_oct_r[ch];
                    pending_r[ch]  <= pending_r[ch];
                end
            end
        end
    end

    genvar gch;
    generate
        for (gch = 0; gch < NUM_CH; gch++) begin : g_pack
            assign bus.oct_active[gch*OCT_W +: OCT_W] = act_r[gch];
        end
    endgenerate

    assign bus.pending  = pending_r;
    assign bus.sq_out   = sq_r;
    assign bus.tick_out = tick_r;

endmodule

// File: tb/tb_octave_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_octave_clk_en_gen
// Directed bench for octave_clk_en_gen: a 4-channel/8-octave instance for the
// main behaviour and a 1-channel/6-octave instance for octave clamping.
// ---------------------------------------------------------------------------
module tb_octave_clk_en_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    octave_clk_en_gen_if #(.NUM_CH(4), .OCT_W(3)) bus0 ();
    octave_clk_en_gen_if #(.NUM_CH(1), .OCT_W(3)) bus1 ();

    octave_clk_en_gen #(.NUM_CH(4), .NUM_OCT(8), .OCT_W(3), .RESET_OCT(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    octave_clk_en_gen #(.NUM_CH(1), .NUM_OCT(6), .OCT_W(3), .RESET_OCT(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;
    int   run_len;
    int   min_phase;
    bit   first_run;
    logic prev_sq;
    logic [15:0] pat_sq;
    logic [15:0] pat_tk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, track the expected count of u_dut0, sample at +1.
    task automatic step();
        @(posedge clk);
        if (bus0.sync_clr) ecnt = 0;
        else if (bus0.run) ecnt = (ecnt + 1) % 256;
        #1;
    endtask

    // Phase-length tracker on sq_out[2]; the first (partial) run is ignored.
    task automatic track();
        if (bus0.sq_out[2] == prev_sq) begin
            run_len++;
        end else begin
            if (!first_run && run_len < min_phase) min_phase = run_len;
            first_run = 1'b0;
            prev_sq   = bus0.sq_out[2];
            run_len   = 1;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus0.run = 1'b0; bus0.sync_clr = 1'b0; bus0.octave_in = 12'd0; bus0.oct_load = 4'd0;
        bus1.run = 1'b0; bus1.sync_clr = 1'b0; bus1.octave_in = 3'd0;  bus1.oct_load = 1'b0;
        #2;
        chk("rst_oct_active", 32'(bus0.oct_active), 32'd0);
        chk("rst_pending",    32'(bus0.pending),    32'd0);
        chk("rst_sq",         32'(bus0.sq_out),     32'd0);
        chk("rst_tick",       32'(bus0.tick_out),   32'd0);
        reset = 1'b1;
        bus0.run = 1'b1;
        bus1.run = 1'b1;

        // Octave 0 everywhere: sq toggles every cycle, tick every second cycle.
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("oct0_sq",   32'(bus0.sq_out),   (k % 2 == 1) ? 32'hF : 32'h0);
            chk("oct0_tick", 32'(bus0.tick_out), (k % 2 == 1) ? 32'h0 : 32'hF);
        end
        chk("oct0_pending", 32'(bus0.pending), 32'd0);

        // Load ch1 with octave 3 at count 5; swap on the 15->16 edge.
        step();
        bus0.octave_in[5:3] = 3'd3; bus0.oct_load = 4'b0010;
        step();
        bus0.oct_load = 4'b0000;
        while (ecnt != 15) step();
        chk("ch1_pending_wait", 32'(bus0.pending[1]),       32'd1);
        chk("ch1_active_wait",  32'(bus0.oct_active[5:3]),  32'd0);
        step();
        chk("ch1_active_swap",  32'(bus0.oct_active[5:3]),  32'd3);
        chk("ch1_pending_swap", 32'(bus0.pending[1]),       32'd0);
        chk("ch1_sq_swap",      32'(bus0.sq_out[1]),        32'd0);
        chk("ch1_tick_swap",    32'(bus0.tick_out[1]),      32'd1);
        pat_sq = 16'h7F80;
        pat_tk = 16'h8000;
        for (int j = 0; j < 16; j++) begin
            step();
            chk("ch1_sq_oct3",   32'(bus0.sq_out[1]),   32'(pat_sq[j]));
            chk("ch1_tick_oct3", 32'(bus0.tick_out[1]), 32'(pat_tk[j]));
        end

        // ch2 to octave 7 (swap at 255->0), then load octave 1 at count 10.
        bus0.octave_in[8:6] = 3'd7; bus0.oct_load = 4'b0100;
        step();
        bus0.oct_load = 4'b0000;
        while (ecnt != 255) step();
        chk("ch2_pending_wait7", 32'(bus0.pending[2]),      32'd1);
        chk("ch2_active_wait7",  32'(bus0.oct_active[8:6]), 32'd0);
        step();
        chk("ch2_active7",       32'(bus0.oct_active[8:6]), 32'd7);
        chk("ch2_pending7",      32'(bus0.pending[2]),      32'd0);
        chk("ch2_tick_swap7",    32'(bus0.tick_out[2]),     32'd1);
        while (ecnt != 10) step();
        bus0.octave_in[8:6] = 3'd1; bus0.oct_load = 4'b0100;
        step();
        bus0.oct_load = 4'b0000;
        chk("ch2_pending_load1", 32'(bus0.pending[2]),      32'd1);
        prev_sq = bus0.sq_out[2]; run_len = 0; first_run = 1'b1; min_phase = 1000;
        for (int j = 0; j < 245; j++) begin
            step();
            track();
        end
        chk("ch2_swap_edge_cnt", 32'(ecnt),                 32'd0);
        chk("ch2_active1",       32'(bus0.oct_active[8:6]), 32'd1);
        chk("ch2_pending1",      32'(bus0.pending[2]),      32'd0);
        chk("ch2_sq_swap1",      32'(bus0.sq_out[2]),       32'd0);
        chk("ch2_tick_swap1",    32'(bus0.tick_out[2]),     32'd1);
        pat_sq = 16'h0066;
        pat_tk = 16'h0088;
        for (int j = 0; j < 8; j++) begin
            step();
            track();
            chk("ch2_sq_oct1",   32'(bus0.sq_out[2]),   32'(pat_sq[j]));
            chk("ch2_tick_oct1", 32'(bus0.tick_out[2]), 32'(pat_tk[j]));
        end
        chk("ch2_min_phase", 32'(min_phase), 32'd2);

        // run=0 for 10 cycles at count 12: everything frozen, no ticks.
        while (ecnt != 12) step();
        bus0.run = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("hold_sq",   32'(bus0.sq_out),   32'h2);
            chk("hold_tick", 32'(bus0.tick_out), 32'h0);
        end
        bus0.run = 1'b1;
        step();
        chk("resume1_sq",   32'(bus0.sq_out),   32'hB);
        chk("resume1_tick", 32'(bus0.tick_out), 32'h0);
        step();
        chk("resume2_sq",   32'(bus0.sq_out),   32'h6);
        chk("resume2_tick", 32'(bus0.tick_out), 32'h9);

        // Pending ch3 octave 5, then sync_clr at count 40 with a ch0 load.
        while (ecnt != 20) step();
        bus0.octave_in[11:9] = 3'd5; bus0.oct_load = 4'b1000;
        step();
        bus0.oct_load = 4'b0000;
        while (ecnt != 40) step();
        chk("clr_pending_before", 32'(bus0.pending), 32'h8);
        bus0.sync_clr = 1'b1;
        bus0.octave_in[2:0] = 3'd2; bus0.oct_load = 4'b0001;
        step();
        bus0.sync_clr = 1'b0; bus0.oct_load = 4'b0000;
        chk("clr_oct_active", 32'(bus0.oct_active), 32'({3'd5, 3'd1, 3'd3, 3'd0}));
        chk("clr_pending",    32'(bus0.pending),    32'h1);
        chk("clr_sq",         32'(bus0.sq_out),     32'h0);
        chk("clr_tick",       32'(bus0.tick_out),   32'h0);
        step();
        chk("clr_next_sq",    32'(bus0.sq_out),     32'h1);
        chk("clr_next_tick",  32'(bus0.tick_out),   32'h0);

        // Asynchronous reset at count 100, between edges.
        while (ecnt != 100) step();
        chk("pre_rst_oct_active", 32'(bus0.oct_active), 32'({3'd5, 3'd1, 3'd3, 3'd2}));
        chk("pre_rst_pending",    32'(bus0.pending),    32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_oct_active", 32'(bus0.oct_active), 32'd0);
        chk("async_rst_pending",    32'(bus0.pending),    32'd0);
        chk("async_rst_sq",         32'(bus0.sq_out),     32'd0);
        chk("async_rst_tick",       32'(bus0.tick_out),   32'd0);
        #2;
        reset = 1'b1;
        ecnt  = 0;

        // NUM_OCT=6 instance: code 7 clamps to octave 5.
        bus1.octave_in = 3'd7; bus1.oct_load = 1'b1;
        step();
        bus1.oct_load = 1'b0;
        chk("clamp_pending_wait", 32'(bus1.pending),    32'd1);
        chk("clamp_active_wait",  32'(bus1.oct_active), 32'd0);
        for (int j = 0; j < 63; j++) step();
        chk("clamp_active",  32'(bus1.oct_active), 32'd5);
        chk("clamp_pending", 32'(bus1.pending),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/octave_clk_en_gen.md
Name: octave_clk_en_gen

Overview:
- Parametrised, fully synchronous successor to the ripple octave divider.
- One shared free-running counter drives NUM_CH independent channels.
- Each channel selects a divide-by-2^(o+1) octave and produces a 50%-duty square wave plus a one-cycle tick enable.
- Octave changes are deferred to a common period boundary so no channel emits a runt pulse; downstream logic stays on the single clk domain.

Parameters:
- NUM_CH, 4: number of independent output channels.
- NUM_OCT, 8: number of octaves; octave o divides by 2^(o+1); counter width = NUM_OCT.
- OCT_W, 3: octave code width per channel; codes >= NUM_OCT clamp to NUM_OCT-1.
- RESET_OCT, 0: active octave of every channel after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- run  in  1  counter advance enable.
- sync_clr  in  1  synchronous counter restart.
- octave_in  in  NUM_CH*OCT_W  requested octave per channel; channel ch uses bits [ch*OCT_W +: OCT_W].
- oct_load  in  NUM_CH  per-channel strobe that captures octave_in into the pending register.
- oct_active  out  NUM_CH*OCT_W  octave currently in effect, after clamping.
- pending  out  NUM_CH  a loaded octave is waiting for its boundary.
- sq_out  out  NUM_CH  divided square wave.
- tick_out  out  NUM_CH  one-cycle enable, once per divided period.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; no clk edge is required:
  - cnt=0.
  - oct_active=clamp(RESET_OCT) for all channels.
  - pending=0.
  - sq_out=0, tick_out=0.
- All outputs are registered.
- Counter: at each edge with run=1 and sync_clr=0, cnt <= cnt+1, wrapping at 2^NUM_OCT. When run=0, cnt holds.
- Per channel, with o = oct_active at the edge:
  - tick_out <= run & (cnt[o:0] all ones), evaluated on the pre-increment count.
  - sq_out <= bit of (cnt+1) selected by the post-swap octave.
  - Result: sq_out falls in the same cycle tick_out rises; period = 2^(o+1) cycles; high and low phases are 2^o cycles each.
- While run=0, tick_out=0 and sq_out holds.
- Load:
  - oct_load[ch]=1 stores clamp(octave_in slice) in pend_oct[ch] and sets pending[ch].
  - A later load before the swap overwrites the stored value; last load wins.
- Swap:
  - Condition: edge with run=1, pending[ch]=1, and cnt[m:0] all ones, where m = max(oct_active, pend_oct).
  - At that edge oct_active <= pend_oct and pending clears.
  - Both the old and new periods end on this edge, so no phase is shorter than min(2^old, 2^new) cycles.
  - Swap latency from the load edge is at most 2^(m+1) cycles.
- Load coinciding with a swap edge: the swap uses the previously pending value; the new load becomes pending (pending stays 1).
- Loading the value already active still goes through the pending/swap sequence with no visible output change.
- sync_clr=1 has priority over run:
  - cnt <= 0.
  - Every pending octave is applied immediately and pending clears.
  - sq_out <= 0, tick_out <= 0.
  - A simultaneous oct_load is captured as pending after the clear.
- Channels are fully independent except for the shared counter; swaps on different channels may occur on the same or different edges.

Test Plan:
- Release reset, run=1, all channels at octave 0 -> sq_out toggles every cycle (0,1,0,1...); tick_out high every 2nd cycle; pending=0.
- Load ch1 with octave 3 at count 5 -> pending[1]=1 until the edge where cnt[3:0]=15 (count 15→16); then oct_active[1]=3, sq_out[1] is 8 cycles high / 8 low, tick_out[1] every 16 cycles.
- ch2 at octave 7, load octave 1 at count 10 -> swap at the 255→0 edge; sq_out[2] never has a phase shorter than 2 cycles; afterwards period 4.
- run=0 for 10 cycles mid-period -> cnt and sq_out frozen, tick_out=0 throughout; on resume the phase continues exactly where it stopped.
- Pending load on ch3 (octave 5) then sync_clr at count 40 -> next cycle cnt=0, oct_active[3]=5, pending[3]=0, all sq_out and tick_out = 0.
- Assert reset at count 100 between clock edges -> outputs go to the reset values immediately; octave_in=7 with NUM_OCT=6 then loads as oct_active=5.
